// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding, frame phases and command codes
// used by the slave, the RAM and the top-level wrapper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Sub-phase inside WRITE/READ_ADD/READ_DATA once the command bit is known
  typedef enum logic [1:0] {
    PH_SHIFT_IN  = 2'd0,
    PH_WAIT_TX   = 2'd1,
    PH_SHIFT_OUT = 2'd2,
    PH_HOLD      = 2'd3
  } phase_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises command frames from MOSI into rx_data/rx_valid and,
// for read-data frames, serialises one byte from tx_data onto MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  state_t             state;
  phase_t             phase;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-2:0] shreg;
  logic               rd_addr_seen;
  logic [DATA_W-1:0]  tx_byte;

  // MISO derives from flops only; reset clears phase so MISO drops asynchronously
  assign MISO = (phase == PH_SHIFT_OUT) ? tx_byte[DATA_W-1] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= PH_SHIFT_IN;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_byte      <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE) begin
        phase   <= PH_SHIFT_IN;
        bit_cnt <= '0;
        if (!SS_n) state <= CHK_CMD;
      end else if (SS_n) begin
        state   <= IDLE;
        phase   <= PH_SHIFT_IN;
        bit_cnt <= '0;
      end else if (state == CHK_CMD) begin
        shreg   <= {{(FRAME_W-2){1'b0}}, MOSI};
        bit_cnt <= 4'(FRAME_W-2);
        phase   <= PH_SHIFT_IN;
        if (!MOSI)             state <= WRITE;
        else if (rd_addr_seen) state <= READ_DATA;
        else                   state <= READ_ADD;
      end else begin
        case (phase)
          PH_SHIFT_IN: begin
            if (bit_cnt == '0) begin
              rx_data  <= {shreg, MOSI};
              rx_valid <= 1'b1;
              phase    <= (state == READ_DATA) ? PH_WAIT_TX : PH_HOLD;
              if (state == READ_ADD)  rd_addr_seen <= 1'b1;
              if (state == READ_DATA) rd_addr_seen <= 1'b0;
            end else begin
              shreg   <= {shreg[FRAME_W-3:0], MOSI};
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
          PH_WAIT_TX: begin
            if (tx_valid) begin
              tx_byte <= tx_data;
              bit_cnt <= 4'(DATA_W-1);
              phase   <= PH_SHIFT_OUT;
            end
          end
          PH_SHIFT_OUT: begin
            tx_byte <= {tx_byte[DATA_W-2:0], 1'b0};
            if (bit_cnt == '0) phase <= PH_HOLD;
            else               bit_cnt <= bit_cnt - 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave with scoreboard queues for rx frames and MISO bits.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb_rx[$];
  logic       sb_miso[$];
  logic [9:0] mon_exp;

  spi_slave #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  // rx_valid monitor: every strobe must match the oldest expected frame
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      checks++;
      assert (sb_rx.size() > 0) else begin
        errors++;
        $error("FAIL rx_unexpected observed=%h expected=no_strobe", rx_data);
      end
      if (sb_rx.size() > 0) begin
        mon_exp = sb_rx.pop_front();
        checks++;
        assert (rx_data === mon_exp) else begin
          errors++;
          $error("FAIL rx_data observed=%h expected=%h", rx_data, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rx_valid is visible
  task automatic send_frame(input string tag, input logic [9:0] f);
    logic bad;
    bad = 1'b0;
    sb_rx.push_back(f);
    SS_n = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      if (MISO !== 1'b0) bad = 1'b1;
      MOSI = f[i];
    end
    @(negedge clk);
    if (MISO !== 1'b0) bad = 1'b1;
    chk(tag, {31'd0, bad}, 32'd0);
  endtask

  task automatic close_frame();
    SS_n = 1'b1;
    @(negedge clk);
    chk("sb_drained", sb_rx.size(), 0);
    chk("idle_after_ss", 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    logic [7:0] rbyte;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    @(negedge clk);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_miso", MISO, 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    send_frame("wa_miso_quiet", 10'h0A5);
    close_frame();
    chk("wa_seen", dut.rd_addr_seen, 0);

    tx_valid = 1'b1; tx_data = 8'hFF;
    send_frame("wd_miso_quiet", 10'h13C);
    close_frame();
    chk("wd_seen", dut.rd_addr_seen, 0);

    send_frame("ra_miso_quiet", 10'h2A5);
    tx_valid = 1'b0;
    chk("ra_state", 32'(dut.state), 32'(READ_ADD));
    chk("ra_seen", dut.rd_addr_seen, 1);
    close_frame();

    send_frame("rd_miso_quiet", 10'h300);
    chk("rd_state", 32'(dut.state), 32'(READ_DATA));
    chk("rd_seen", dut.rd_addr_seen, 0);
    rbyte = 8'h3C;
    tx_valid = 1'b1; tx_data = rbyte;
    for (int k = 7; k >= 0; k--) sb_miso.push_back(rbyte[k]);
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      chk("miso_bit", MISO, sb_miso.pop_front());
      if (k == 3) tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("miso_after_byte", MISO, 0);
    @(negedge clk);
    chk("miso_hold", MISO, 0);
    chk("rd_hold_state", 32'(dut.state), 32'(READ_DATA));
    close_frame();

    SS_n = 1'b0;
    @(negedge clk); MOSI = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); MOSI = k[0];
    end
    @(negedge clk); SS_n = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_rx_data", rx_data, 10'h300);
    chk("abort_seen", dut.rd_addr_seen, 0);
    repeat (3) @(negedge clk);

    send_frame("b2b_a_miso", 10'h0F0);
    close_frame();
    send_frame("b2b_b_miso", 10'h155);
    close_frame();

    send_frame("ra2_miso", 10'h2C3);
    close_frame();
    send_frame("bit8_miso", 10'h244);
    chk("bit8_state", 32'(dut.state), 32'(READ_DATA));
    chk("bit8_seen", dut.rd_addr_seen, 0);
    close_frame();

    send_frame("rst_ra_miso", 10'h211);
    close_frame();
    send_frame("rst_rd_miso", 10'h322);
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("pre_rst_miso0", MISO, 1);
    @(negedge clk);
    chk("pre_rst_miso1", MISO, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_miso", MISO, 0);
    chk("async_state", 32'(dut.state), 32'(IDLE));
    chk("async_rx_data", rx_data, 0);
    chk("async_seen", dut.rd_addr_seen, 0);
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame("post_rst_miso", 10'h05A);
    close_frame();
    send_frame("post_rst_ra_miso", 10'h381);
    chk("post_rst_state", 32'(dut.state), 32'(READ_ADD));
    close_frame();

    chk("sb_final", sb_rx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter FRAME_W, default 10, meaning command frame width (2 command bits + 8 payload bits).
REQ-002 SHALL have parameter DATA_W, default 8, meaning read-data width returned to master.
REQ-003 clk  input  1  single system clock; MOSI sampled and MISO updated on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 SS_n  input  1  slave select from master, active low; high aborts any frame.
REQ-006 MOSI  input  1  serial data from master, MSB first.
REQ-007 MISO  output  1  serial read data to master, MSB first.
REQ-008 rx_data  output  FRAME_W  parallel frame to RAM: [9:8] command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
REQ-009 rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-010 tx_data  input  DATA_W  read byte from RAM.
REQ-011 tx_valid  input  1  tx_data valid this cycle.

Function
REQ-012 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-013 IDLE: SS_n=0 -> CHK_CMD next cycle; else stay.
REQ-014 CHK_CMD: MOSI sampled as frame bit 9; MOSI=0 -> WRITE; MOSI=1 and rd_addr_seen=0 -> READ_ADD; MOSI=1 and rd_addr_seen=1 -> READ_DATA.
REQ-015 WRITE/READ_ADD/READ_DATA SHALL shift 9 further MOSI bits (bits 8..0), one per cycle, via 4-bit bit counter.
REQ-016 On the cycle after bit 0 is sampled, rx_data SHALL hold the full frame and rx_valid SHALL be 1 for exactly one cycle; rx_data holds until next frame completes.
REQ-017 rd_addr_seen SHALL set on completion of a READ_ADD frame and clear on completion of a READ_DATA frame; WRITE frames leave it unchanged.
REQ-018 READ_DATA: after rx_valid, slave SHALL wait for tx_valid=1, latch tx_data, then drive MISO with bits 7..0 on the 8 following cycles.
REQ-019 tx_valid outside READ_DATA wait phase SHALL be ignored.
REQ-020 After frame (or MISO byte) completes, FSM SHALL stay in its state with MISO=0 until SS_n=1, then return to IDLE.
REQ-021 SS_n=1 in any non-IDLE state SHALL return to IDLE next cycle, discard partial frame, emit no rx_valid, leave rd_addr_seen unchanged.
REQ-022 MISO SHALL be 0 whenever not shifting read data.
REQ-023 Command bit 8 received SHALL be passed through unchecked; slave does not validate consistency of bit 8 with state.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0, latched tx byte=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no rx_valid; first frame after release starts from IDLE.

Structure
REQ-026 Shared package spi_pkg SHALL hold state enum and command constants (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11) for reuse by RAM and top wrapper.
REQ-027 Single module, no sub-modules; top-level wrapper connects rx_data/rx_valid to RAM din/rx_valid and RAM dout/tx_valid to tx_data/tx_valid.

Verification
REQ-028 Write address: SS_n low, MOSI 0,0,0x A5 bits -> rx_data=0x0A5, rx_valid pulse 1 cycle, MISO=0 throughout.
REQ-029 Write data: frame 01_0x3C -> rx_data=0x13C, one rx_valid; rd_addr_seen stays 0.
REQ-030 Read sequence: frame 10_0xA5 -> READ_ADD, rx_data=0x2A5; next frame 11_0x00 -> READ_DATA, rx_data=0x300; tx_valid with tx_data=0x3C -> MISO shows 0,0,1,1,1,1,0,0 over 8 cycles; rd_addr_seen cleared.
REQ-031 Abort: SS_n high after 5 bits of WRITE -> IDLE next cycle, no rx_valid, rx_data unchanged.
REQ-032 Async reset during READ_DATA shift -> MISO=0, state IDLE immediately, no clock required.
REQ-033 Back-to-back frames with one SS_n-high cycle between -> both frames produce correct rx_data and one rx_valid each.
